// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//   Two-way set-associative, write-through, no-write-allocate data cache that
//   sits between the MEM-stage pipeline register and the SRAM controller.
//   Read hits complete combinationally in the request cycle; read misses
//   fetch a 64-bit line; every store is forwarded to SRAM and also updates
//   the cached copy when the address hits.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   read_en, write_en : MEM-stage load / store request (store has priority)
//   address           : byte address; [2] word, [IDX+2:3] index, tag above
//   write_data        : store data
//   read_data         : load result (0 when no read completes this cycle)
//   ready             : request complete or no request (pipeline freeze)
//   sram_*            : line-fetch / word-write handshake to SRAM controller
//   hit_count, miss_count : read statistics, present only with
//                           CACHE_STATS_EN defined
//
// Optional feature macro: CACHE_STATS_EN
// ---------------------------------------------------------------------------
module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_read_en,
    output logic        sram_write_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [63:0] sram_read_data,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = 3 + IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [SETS-1:0]  lru_reg;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             off;

    logic [1:0]       way_valid;
    logic [1:0]       way_hit;
    logic [1:0][31:0] way_word;

    logic             hit;
    logic             hit_way;
    logic             victim;
    logic [31:0]      hit_word;
    logic [31:0]      sram_word;

    logic             fill_en;
    logic             word_wr_en;
    logic             lru_we;
    logic             lru_val;
    logic             hit_inc;

    assign idx = address[3 +: IDX_W];
    assign tag = address[TAG_LSB +: TAG_W];
    assign off = address[2];

    // -----------------------------------------------------------------------
    // Per-way storage. Only valid bits need reset; tags and data are
    // don't-care while their valid bit is clear.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            localparam logic WAY = (gi == 1);

            logic [SETS-1:0]  valid_reg;
            logic [TAG_W-1:0] tag_mem [SETS];
            logic [31:0]      lo_mem  [SETS];
            logic [31:0]      hi_mem  [SETS];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (fill_en && victim == WAY) begin
                    valid_reg[idx] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_en && victim == WAY) begin
                    tag_mem[idx] <= tag;
                    lo_mem[idx]  <= sram_read_data[31:0];
                    hi_mem[idx]  <= sram_read_data[63:32];
                end
                if (word_wr_en && hit_way == WAY) begin
                    if (off) begin
                        hi_mem[idx] <= write_data;
                    end else begin
                        lo_mem[idx] <= write_data;
                    end
                end
            end

            assign way_valid[gi] = valid_reg[idx];
            assign way_hit[gi]   = valid_reg[idx] && (tag_mem[idx] == tag);
            assign way_word[gi]  = off ? hi_mem[idx] : lo_mem[idx];
        end
    endgenerate

    // Way 0 wins if both ways claim a hit.
    assign hit      = |way_hit;
    assign hit_way  = ~way_hit[0];
    assign hit_word = way_word[hit_way];

    // Fill an empty way first, lowest index first; otherwise follow lru.
    assign victim = !way_valid[0] ? 1'b0 :
                    !way_valid[1] ? 1'b1 : lru_reg[idx];

    assign sram_word = off ? sram_read_data[63:32] : sram_read_data[31:0];

    // Line fetches are always issued line-aligned.
    assign sram_address    = write_en ? address : {address[31:3], 3'b000};
    assign sram_write_data = write_data;

    // -----------------------------------------------------------------------
    // Control: all outputs are combinational from state and inputs.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        ready         = 1'b1;
        read_data     = 32'd0;
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
        fill_en       = 1'b0;
        word_wr_en    = 1'b0;
        lru_we        = 1'b0;
        lru_val       = 1'b0;
        hit_inc       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (write_en) begin
                    sram_write_en = 1'b1;
                    ready         = 1'b0;
                    if (sram_ready) begin
                        ready      = 1'b1;
                        word_wr_en = hit;
                        lru_we     = hit;
                        lru_val    = ~hit_way;
                    end else begin
                        state_next = S_WRITE;
                    end
                end else if (read_en) begin
                    if (hit) begin
                        read_data = hit_word;
                        lru_we    = 1'b1;
                        lru_val   = ~hit_way;
                        hit_inc   = 1'b1;
                    end else begin
                        sram_read_en = 1'b1;
                        ready        = 1'b0;
                        if (sram_ready) begin
                            ready     = 1'b1;
                            read_data = sram_word;
                            fill_en   = 1'b1;
                            lru_we    = 1'b1;
                            lru_val   = ~victim;
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                end
            end
            S_FETCH: begin
                sram_read_en = 1'b1;
                ready        = 1'b0;
                if (sram_ready) begin
                    ready      = 1'b1;
                    read_data  = sram_word;
                    fill_en    = 1'b1;
                    lru_we     = 1'b1;
                    lru_val    = ~victim;
                    state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                sram_write_en = 1'b1;
                ready         = 1'b0;
                if (sram_ready) begin
                    ready      = 1'b1;
                    word_wr_en = hit;
                    lru_we     = hit;
                    lru_val    = ~hit_way;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Reset silences the SRAM side immediately, even mid-transaction.
        if (rst) begin
            sram_read_en  = 1'b0;
            sram_write_en = 1'b0;
            fill_en       = 1'b0;
            word_wr_en    = 1'b0;
            lru_we        = 1'b0;
            hit_inc       = 1'b0;
            state_next    = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_reg <= '0;
        end else if (lru_we) begin
            lru_reg[idx] <= lru_val;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit_inc) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill_en) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//   Directed-vector bench for cache_controller. The stimulus process issues
//   requests and pushes the hand-computed expected response into a queue;
//   a monitor pops and compares each time a request completes (ready=1).
//   A small SRAM controller model answers after a fixed latency.
// ---------------------------------------------------------------------------
module tb_cache_controller;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [63:0] sram_read_data;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    cache_controller #(.SETS(64), .TAG_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .read_en         (read_en),
        .write_en        (write_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .sram_read_en    (sram_read_en),
        .sram_write_en   (sram_write_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- SRAM controller model ----------------
    logic [31:0] smem [logic [31:0]];
    logic        req_n = 1'b0;
    int          cnt   = 0;

    function automatic logic [31:0] wordf(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    always @(negedge clk) begin
        req_n = (sram_read_en || sram_write_en) && !sram_ready && !rst;
    end

    initial begin
        sram_ready     = 1'b0;
        sram_read_data = 64'd0;
        smem[32'h10]   = 32'hAAAA_AAAA;
        smem[32'h14]   = 32'hBBBB_BBBB;
        forever begin
            @(posedge clk);
            #2;
            if (sram_ready) begin
                sram_ready = 1'b0;
                cnt = 0;
            end else if (req_n) begin
                cnt++;
                if (cnt == LAT) begin
                    sram_ready = 1'b1;
                    if (sram_write_en) begin
                        smem[sram_address] = sram_write_data;
                    end else begin
                        sram_read_data = {wordf(sram_address | 32'h4), wordf(sram_address)};
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        miss;
        int          lat;
        logic [31:0] saddr;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int   mon_cycles = 0;
    logic mon_fetch  = 1'b0;
    logic mon_held   = 1'b1;
    logic mon_both   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_cycles = 0;
            mon_fetch  = 1'b0;
            mon_held   = 1'b1;
            mon_both   = 1'b0;
        end else if (read_en || write_en) begin
            if (sram_read_en) mon_fetch = 1'b1;
            if (sram_read_en && sram_write_en) mon_both = 1'b1;
            if (write_en && !ready && !sram_write_en) mon_held = 1'b0;
            if (ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got addr %h expected no transaction", address);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    $display("txn %s addr=%h data=%h fetch=%0b cycles=%0d",
                             e.wr ? "WR" : "RD", address, read_data, mon_fetch, mon_cycles);
                    if (!e.wr) check("read_data", read_data, e.data);
                    if (e.wr) check("write_en_held", 32'(mon_held), 32'd1);
                    check("miss_fetch", 32'(mon_fetch), 32'(e.miss));
                    check("latency", mon_cycles, e.lat);
                    check("sram_address", sram_address, e.saddr);
                    check("no_rd_wr_overlap", 32'(mon_both), 32'd0);
                end
                mon_cycles = 0;
                mon_fetch  = 1'b0;
                mon_held   = 1'b1;
                mon_both   = 1'b0;
            end else begin
                mon_cycles++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_miss);
        exp_t e;
        int   n;
        e.wr    = wr;
        e.data  = exp_data;
        e.miss  = exp_miss;
        e.lat   = (wr || exp_miss) ? LAT : 0;
        e.saddr = wr ? addr : {addr[31:3], 3'b000};
        sbq.push_back(e);
        read_en    = !wr;
        write_en   = wr;
        address    = addr;
        write_data = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 50);
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL timeout: addr %h got ready 0 expected 1 within 50 cycles", addr);
        end
        step();
        read_en  = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_sram_rd", 32'(sram_read_en), 32'd0);
        check("rst_sram_wr", 32'(sram_write_en), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        read_en    = 1'b0;
        write_en   = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        step();
        pulse_reset();

        // First miss and the hit on the other word of the same line.
        txn(1'b0, 32'h0000_0010, 32'd0, 32'hAAAA_AAAA, 1'b1);
        txn(1'b0, 32'h0000_0014, 32'd0, 32'hBBBB_BBBB, 1'b0);

        // LRU replacement in set 2: tags 1,2 filled, tag 1 touched, tag 3 evicts tag 2.
        pulse_reset();
        txn(1'b0, 32'h0000_0210, 32'd0, 32'h584A_0210, 1'b1);
        txn(1'b0, 32'h0000_0410, 32'd0, 32'h5E4A_0410, 1'b1);
        txn(1'b0, 32'h0000_0214, 32'd0, 32'h584E_0214, 1'b0);
        txn(1'b0, 32'h0000_0610, 32'd0, 32'h5C4A_0610, 1'b1);
        txn(1'b0, 32'h0000_0210, 32'd0, 32'h584A_0210, 1'b0);
        txn(1'b0, 32'h0000_0410, 32'd0, 32'h5E4A_0410, 1'b1);

        // Write hit updates the cached word; the neighbour word is untouched.
        txn(1'b1, 32'h0000_0214, 32'h1234_5678, 32'd0, 1'b0);
        txn(1'b0, 32'h0000_0214, 32'd0, 32'h1234_5678, 1'b0);
        txn(1'b0, 32'h0000_0210, 32'd0, 32'h584A_0210, 1'b0);

        // Write miss does not allocate.
        txn(1'b1, 32'h0000_0A28, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn(1'b0, 32'h0000_0A28, 32'd0, 32'hDEAD_BEEF, 1'b1);

        // Reset in the middle of a line fetch.
        read_en = 1'b1;
        address = 32'h0000_1000;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_fetch_sram_rd", 32'(sram_read_en), 32'd0);
        read_en = 1'b0;
        #1;
        check("rst_mid_fetch_ready", 32'(ready), 32'd1);
        check("rst_mid_fetch_data", read_data, 32'd0);
        step();
        rst = 1'b0;

        // Previously cached line is gone; then 3 hits and 2 misses overall.
        txn(1'b0, 32'h0000_0214, 32'd0, 32'h1234_5678, 1'b1);
        txn(1'b0, 32'h0000_0214, 32'd0, 32'h1234_5678, 1'b0);
        txn(1'b0, 32'h0000_0210, 32'd0, 32'h584A_0210, 1'b0);
        txn(1'b0, 32'h0000_0818, 32'd0, 32'h5242_0818, 1'b1);
        txn(1'b0, 32'h0000_081C, 32'd0, 32'h5246_081C, 1'b0);

        step();
        step();
        check("scoreboard_empty", sbq.size(), 32'd0);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'd3);
        check("miss_count", miss_count, 32'd2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
